// File: rtl/fmac_accum_seq_ctrl.sv
// Issue sequencer for the FP MAC accumulate loop: one operand pair in flight at a time.
// Optional WAIT-cycle counter on stall_cnt, built only when FMAC_SEQ_STALL_CNT_EN is defined.
module fmac_accum_seq_ctrl #(
    parameter int PIPE_LAT  = 4,
    parameter int CNT_W     = 8,
    parameter int TMO_SLACK = 2
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             issue_valid,
    output logic             acc_sel,
    input  logic             res_valid,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] elem_cnt,
    output logic [15:0]      stall_cnt
);

    localparam int TMO    = PIPE_LAT + TMO_SLACK;
    localparam int WAIT_W = $clog2(TMO + 1);
    localparam logic [WAIT_W-1:0] TMO_V = WAIT_W'(TMO);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_remaining;
    logic [CNT_W-1:0]    r_elem_cnt;
    logic [WAIT_W-1:0]   r_wait;
    logic [WAIT_W-1:0]   w_wait_inc;
    logic                r_err;
    logic                w_start_acc;
    logic                w_issue;
    logic                w_timeout;
    logic                w_spurious;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        issue_valid = 1'b0;
        acc_sel     = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        w_start_acc = 1'b0;
        w_issue     = 1'b0;
        w_timeout   = 1'b0;
        w_spurious  = res_valid;
        w_wait_inc  = r_wait + 1'b1;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_start_acc = 1'b1;
                    w_state_nxt = (len == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    issue_valid = 1'b1;
                    w_issue     = 1'b1;
                    acc_sel     = (r_elem_cnt != '0);
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                w_spurious = 1'b0;
                // A return in the final allowed cycle still wins over the timeout.
                if (res_valid) begin
                    w_state_nxt = (r_remaining == '0) ? S_DONE : S_ISSUE;
                end else if (w_wait_inc == TMO_V) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_remaining <= '0;
            r_elem_cnt  <= '0;
            r_wait      <= '0;
        end else if (w_start_acc) begin
            r_remaining <= len;
            r_elem_cnt  <= '0;
        end else if (w_issue) begin
            r_remaining <= r_remaining - 1'b1;
            r_elem_cnt  <= r_elem_cnt + 1'b1;
            r_wait      <= '0;
        end else if (r_state == S_WAIT) begin
            r_wait      <= w_wait_inc;
        end
    end

    // Error sources take priority over the clear from an accepted start.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_err <= 1'b0;
        end else begin
            if (w_start_acc)             r_err <= 1'b0;
            if (w_spurious || w_timeout) r_err <= 1'b1;
        end
    end

    assign err      = r_err;
    assign elem_cnt = r_elem_cnt;

`ifdef FMAC_SEQ_STALL_CNT_EN
    logic [15:0] r_stall;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)                                        r_stall <= '0;
        else if (w_start_acc)                               r_stall <= '0;
        else if (r_state == S_WAIT && r_stall != 16'hFFFF)  r_stall <= r_stall + 1'b1;
    end

    assign stall_cnt = r_stall;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fmac_accum_seq_ctrl.sv
// Bench for fmac_accum_seq_ctrl: directed jobs plus randomized jobs against a timeline
// planner that derives issue/return/done cycles arithmetically from the job description.
module tb_fmac_accum_seq_ctrl;

    localparam int PL  = 4;
    localparam int CW  = 8;
    localparam int SL  = 2;
    localparam int TMO = PL + SL;
    localparam int MAXC = 128;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] len = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          issue_valid;
    logic          acc_sel;
    logic          res_valid = 1'b0;
    logic          busy;
    logic          done;
    logic          err;
    logic [CW-1:0] elem_cnt;
    logic [15:0]   stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    int p_dly[8];
    int p_lat[8];
    bit drv_iv[MAXC];
    bit drv_res[MAXC];
    bit x_iv[MAXC];
    bit x_acc[MAXC];
    bit x_rdy[MAXC];

    fmac_accum_seq_ctrl #(
        .PIPE_LAT (PL),
        .CNT_W    (CW),
        .TMO_SLACK(SL)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .start      (start),
        .len        (len),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .issue_valid(issue_valid),
        .acc_sel    (acc_sel),
        .res_valid  (res_valid),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .elem_cnt   (elem_cnt),
        .stall_cnt  (stall_cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Caller is positioned 1 time unit after a rising edge with the DUT in IDLE.
    // Cycle r=0 is the start cycle; element k waits p_dly[k] cycles in ISSUE and its
    // result returns p_lat[k] cycles after issue (p_lat > TMO means it never returns).
    task automatic run_job(input int n, input bit noise);
        int t, issue, done_at, issued, stall;
        bit timed_out;
        for (int r = 0; r < MAXC; r++) begin
            drv_iv[r] = 1'b0; drv_res[r] = 1'b0;
            x_iv[r] = 1'b0; x_acc[r] = 1'b0; x_rdy[r] = 1'b0;
        end
        t = 1; issued = 0; stall = 0; timed_out = 1'b0; done_at = 1;
        for (int k = 0; k < n; k++) begin
            issue = t + p_dly[k];
            for (int r = t; r <= issue; r++) x_rdy[r] = 1'b1;
            drv_iv[issue] = 1'b1;
            x_iv[issue]   = 1'b1;
            x_acc[issue]  = (k != 0);
            issued++;
            if (p_lat[k] > TMO) begin
                stall += TMO;
                done_at = issue + TMO + 1;
                timed_out = 1'b1;
                break;
            end
            drv_res[issue + p_lat[k]] = 1'b1;
            stall += p_lat[k];
            t = issue + p_lat[k] + 1;
        end
        if (!timed_out) done_at = t;
        if (noise)
            for (int r = 0; r <= done_at + 1; r++)
                if (!x_rdy[r]) drv_iv[r] = 1'($urandom_range(1));

        for (int r = 0; r <= done_at + 1; r++) begin
            start     = (r == 0) || (noise && r <= done_at && $urandom_range(3) == 0);
            len       = (r == 0) ? CW'(n) : CW'($urandom_range(255));
            in_valid  = drv_iv[r];
            res_valid = drv_res[r];
            @(negedge clock);
            chk("issue_valid", 32'(issue_valid), 32'(x_iv[r]));
            if (x_iv[r]) chk("acc_sel", 32'(acc_sel), 32'(x_acc[r]));
            chk("in_ready", 32'(in_ready), 32'(x_rdy[r]));
            chk("busy", 32'(busy), 32'(r >= 1 && r <= done_at));
            chk("done", 32'(done), 32'(r == done_at));
            if (r >= 1) chk("err", 32'(err), 32'(timed_out && r >= done_at));
            @(posedge clock);
            #1;
        end
        start = 1'b0; in_valid = 1'b0; res_valid = 1'b0;
        chk("elem_cnt", 32'(elem_cnt), 32'(issued));
`ifdef FMAC_SEQ_STALL_CNT_EN
        chk("stall_cnt", 32'(stall_cnt), 32'(stall));
`else
        chk("stall_cnt", 32'(stall_cnt), 32'(0));
`endif
    endtask

    initial begin
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'(0));
        chk("rst_issue", 32'(issue_valid), 32'(0));
        chk("rst_acc_sel", 32'(acc_sel), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_err", 32'(err), 32'(0));
        chk("rst_elem_cnt", 32'(elem_cnt), 32'(0));
        chk("rst_stall", 32'(stall_cnt), 32'(0));
        repeat (2) @(posedge clock);
        #1 resetn = 1'b1;
        @(posedge clock); #1;

        // len=3, nominal latency: issues at 1, 6, 11 and done at 16
        for (int k = 0; k < 8; k++) begin p_dly[k] = 0; p_lat[k] = PL; end
        run_job(3, 1'b0);

        // len=0: done one cycle after start, no issue
        run_job(0, 1'b0);

        // len=2 with in_valid withheld 5 cycles in ISSUE
        p_dly[0] = 5;
        run_job(2, 1'b0);

        // result suppressed after the first issue -> timeout
        p_dly[0] = 0; p_lat[0] = TMO + 1;
        run_job(3, 1'b0);

        // next accepted start clears err (checked at r=1 inside run_job)
        p_lat[0] = PL;
        run_job(1, 1'b0);

        // spurious res_valid in IDLE
        res_valid = 1'b1;
        @(posedge clock); #1;
        res_valid = 1'b0;
        @(negedge clock);
        chk("spurious_err", 32'(err), 32'(1));
        chk("spurious_busy", 32'(busy), 32'(0));
        @(posedge clock); #1;

        // reset asserted mid-WAIT
        start = 1'b1; len = CW'(3);
        @(posedge clock); #1;
        start = 1'b0; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(posedge clock); #2;
        resetn = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'(0));
        chk("mid_rst_done", 32'(done), 32'(0));
        chk("mid_rst_in_ready", 32'(in_ready), 32'(0));
        chk("mid_rst_err", 32'(err), 32'(0));
        chk("mid_rst_elem_cnt", 32'(elem_cnt), 32'(0));
        chk("mid_rst_stall", 32'(stall_cnt), 32'(0));
        @(posedge clock); #1;
        resetn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            res_valid = (i == 2);
            @(negedge clock);
            chk("post_rst_done", 32'(done), 32'(0));
            chk("post_rst_busy", 32'(busy), 32'(0));
            @(posedge clock); #1;
        end
        res_valid = 1'b0;

        // randomized jobs with start/in_valid noise while busy
        for (int j = 0; j < 40; j++) begin
            int n;
            n = int'($urandom_range(6));
            for (int k = 0; k < 8; k++) begin
                p_dly[k] = int'($urandom_range(3));
                p_lat[k] = ($urandom_range(7) == 0) ? TMO + 1 : int'($urandom_range(TMO, 1));
            end
            run_job(n, 1'b1);
            if ($urandom_range(3) == 0) begin
                res_valid = 1'b1;
                @(posedge clock); #1;
                res_valid = 1'b0;
                @(negedge clock);
                chk("rand_spurious_err", 32'(err), 32'(1));
                @(posedge clock); #1;
            end
            repeat ($urandom_range(2)) begin
                @(posedge clock); #1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
